// File: rtl/conv_engine_pkg.sv
// Shared constants, types and helpers for the 2x2 convolution engine.
package conv_engine_pkg;

    // Datapath widths
    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int ACCW = 20;

    // Operand/result RAM map
    localparam int A_BASE = 0;
    localparam int B_BASE = 16;
    localparam int C_BASE = 25;

    // Array geometry
    localparam int N_A    = 16;
    localparam int N_B    = 9;
    localparam int N_C    = 4;
    localparam int N_TAPS = 9;

    // Sequencer states (kept as plain constants for compatibility with older blocks)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef logic [DW-1:0]   data_t;
    typedef logic [AW-1:0]   addr_t;
    typedef logic [ACCW-1:0] acc_t;

    // One RAM write beat; also used to hold the bus value between writes
    typedef struct packed {
        addr_t addr;
        data_t data;
    } wr_beat_t;

    // Clamp an accumulator to the 8-bit result range
    function automatic data_t saturate(input acc_t v);
        return (v > acc_t'(255)) ? data_t'(8'hFF) : v[DW-1:0];
    endfunction

    // True when the accumulator does not fit in a result byte
    function automatic logic overflows(input acc_t v);
        return v > acc_t'(255);
    endfunction

endpackage

// File: rtl/conv_engine_if.sv
// Operand read bus and result write port between the RAM and the engine.
interface conv_engine_if;
    import conv_engine_pkg::*;

    logic                   start;
    logic [N_A-1:0][DW-1:0] a;      // a[0] = a00 ... a[15] = a33, row-major
    logic [N_B-1:0][DW-1:0] b;      // b[0] = b00 ... b[8]  = b22, row-major
    logic                   wr_en;
    addr_t                  wr_addr;
    data_t                  wr_data;
    logic                   busy;
    logic                   done;
    logic                   ovf;

    // RAM / host side
    modport master (
        output start, a, b,
        input  wr_en, wr_addr, wr_data, busy, done, ovf
    );

    // Engine side
    modport slave (
        input  start, a, b,
        output wr_en, wr_addr, wr_data, busy, done, ovf
    );

endinterface

// File: rtl/conv_engine_pe.sv
// Single multiply-accumulate cell; one per output pixel.
module conv_pe
    import conv_engine_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    input  data_t a,
    input  data_t b,
    output acc_t  acc
);

    logic [2*DW-1:0] prod;
    acc_t            acc_reg;

    assign prod = a * b;
    assign acc  = acc_reg;

    // Accumulate one product per enabled cycle; clr starts a fresh sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + acc_t'(prod);
        end
    end

endmodule

// File: rtl/conv_engine.sv
// 2x2 valid convolution of a 4x4 matrix by a 3x3 kernel, results written back to RAM.
module conv_engine
    import conv_engine_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    conv_engine_if.slave  bus
);

    logic [1:0]             state_reg;
    logic [3:0]             tap_reg;
    logic [1:0]             idx_reg;
    logic [N_A-1:0][DW-1:0] a_snap_reg;
    logic [N_B-1:0][DW-1:0] b_snap_reg;
    logic                   ovf_reg;
    wr_beat_t               last_beat_reg;

    logic [1:0] kr;
    logic [1:0] kc;
    logic [3:0] b_sel;
    logic       pe_clr;
    logic       pe_en;
    logic       writing;
    acc_t       acc_arr [N_C];
    acc_t       cur_acc;
    data_t      cur_data;
    addr_t      cur_addr;

    // Split the tap index into kernel row/column
    always_comb begin
        kr = 2'd0;
        kc = 2'd0;
        case (tap_reg)
            4'd0: begin kr = 2'd0; kc = 2'd0; end
            4'd1: begin kr = 2'd0; kc = 2'd1; end
            4'd2: begin kr = 2'd0; kc = 2'd2; end
            4'd3: begin kr = 2'd1; kc = 2'd0; end
            4'd4: begin kr = 2'd1; kc = 2'd1; end
            4'd5: begin kr = 2'd1; kc = 2'd2; end
            4'd6: begin kr = 2'd2; kc = 2'd0; end
            4'd7: begin kr = 2'd2; kc = 2'd1; end
            4'd8: begin kr = 2'd2; kc = 2'd2; end
            default: begin kr = 2'd0; kc = 2'd0; end
        endcase
    end

    assign b_sel  = 4'((int'(kr) * 3) + int'(kc));
    assign pe_clr = (state_reg == ST_IDLE) && bus.start;
    assign pe_en  = (state_reg == ST_MAC);

    // 2x2 PE array: PE(i,j) sees A[i+kr][j+kc] and the shared kernel tap
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_row
            for (genvar gj = 0; gj < 2; gj++) begin : g_col
                logic [3:0] a_sel;
                assign a_sel = 4'(((gi + int'(kr)) * 4) + gj + int'(kc));

                conv_pe u_pe (
                    .clk (clk),
                    .rst (rst),
                    .clr (pe_clr),
                    .en  (pe_en),
                    .a   (a_snap_reg[a_sel]),
                    .b   (b_snap_reg[b_sel]),
                    .acc (acc_arr[gi*2 + gj])
                );
            end
        end
    endgenerate

    // Result currently being written, clamped to a byte
    assign cur_acc  = acc_arr[idx_reg];
    assign cur_data = saturate(cur_acc);
    assign cur_addr = addr_t'(C_BASE) + addr_t'(idx_reg);
    assign writing  = (state_reg == ST_WRITE);

    // Outputs decode from state; the write bus holds its last beat when idle
    assign bus.wr_en   = writing;
    assign bus.wr_addr = writing ? cur_addr : last_beat_reg.addr;
    assign bus.wr_data = writing ? cur_data : last_beat_reg.data;
    assign bus.busy    = (state_reg != ST_IDLE);
    assign bus.done    = (state_reg == ST_DONE);
    assign bus.ovf     = ovf_reg;

    // Sequencer: snapshot operands, run nine taps, write four results, pulse done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            tap_reg       <= '0;
            idx_reg       <= '0;
            a_snap_reg    <= '0;
            b_snap_reg    <= '0;
            ovf_reg       <= 1'b0;
            last_beat_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_snap_reg <= bus.a;
                        b_snap_reg <= bus.b;
                        ovf_reg    <= 1'b0;
                        tap_reg    <= '0;
                        state_reg  <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    tap_reg <= tap_reg + 4'd1;
                    if (tap_reg == 4'(N_TAPS - 1)) begin
                        idx_reg   <= '0;
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    last_beat_reg <= '{addr: cur_addr, data: cur_data};
                    if (overflows(cur_acc)) begin
                        ovf_reg <= 1'b1;
                    end
                    idx_reg <= idx_reg + 2'd1;
                    if (idx_reg == 2'(N_C - 1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_engine.sv
// Randomized and directed bench for conv_engine against a plain-arithmetic model.
module tb_conv_engine;
    import conv_engine_pkg::*;

    logic clk;
    logic rst;

    conv_engine_if bus();

    conv_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand image (A at 0..15, B at 16..24), owned by the stimulus process
    int img [25];
    // Result region as written by the engine
    int c_mem [4];

    int n_checks = 0;
    int n_fail   = 0;

    int exp_c [4];
    bit exp_ovf;

    always_comb begin
        for (int i = 0; i < N_A; i++) bus.a[i] = img[i][7:0];
        for (int i = 0; i < N_B; i++) bus.b[i] = img[16 + i][7:0];
    end

    always @(posedge clk) begin
        if (bus.wr_en && bus.wr_addr >= 5'd25 && bus.wr_addr <= 5'd28)
            c_mem[int'(bus.wr_addr) - 25] <= int'(bus.wr_data);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic load_default();
        int a_def [16] = '{4, 6, 5, 1, 1, 2, 3, 4, 7, 8, 9, 3, 5, 7, 2, 7};
        int b_def [9]  = '{2, 3, 2, 4, 6, 5, 1, 7, 1};
        for (int i = 0; i < 16; i++) img[i] = a_def[i];
        for (int i = 0; i < 9; i++) img[16 + i] = b_def[i];
    endtask

    // Reference: direct 2D valid convolution with byte saturation
    function automatic void model();
        exp_ovf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s = 0;
                for (int k = 0; k < 3; k++)
                    for (int l = 0; l < 3; l++)
                        s += img[(i + k) * 4 + (j + l)] * img[16 + k * 3 + l];
                if (s > 255) begin
                    exp_c[i * 2 + j] = 255;
                    exp_ovf = 1'b1;
                end else begin
                    exp_c[i * 2 + j] = s;
                end
            end
        end
    endfunction

    task automatic run_conv(input string name, input bit fixed, input bit extra_starts, input bit poke);
        int got_addr [4];
        int got_data [4];
        int nwr = 0;
        int ndone = 0;
        int nbusy = 0;
        int first_wr = -1;
        int done_cyc = -1;

        if (fixed) begin
            exp_c[0] = 139; exp_c[1] = 149; exp_c[2] = 191; exp_c[3] = 150;
            exp_ovf = 1'b0;
        end else begin
            model();
        end
        for (int i = 0; i < 4; i++) begin
            got_addr[i] = -1;
            got_data[i] = -1;
        end

        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bus.start = extra_starts && (cyc == 3 || cyc == 12);
            if (poke && cyc == 4) img[0] = 0;
            if (bus.wr_en) begin
                if (nwr < 4) begin
                    got_addr[nwr] = int'(bus.wr_addr);
                    got_data[nwr] = int'(bus.wr_data);
                end
                $display("%s: wr cyc=%0d addr=%0d data=%0d", name, cyc, bus.wr_addr, bus.wr_data);
                if (first_wr < 0) first_wr = cyc;
                nwr++;
            end
            if (bus.done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bus.busy) nbusy++;
        end

        check_eq({name, ".nwr"}, nwr, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s.addr%0d", name, i), got_addr[i], 25 + i);
            check_eq($sformatf("%s.data%0d", name, i), got_data[i], exp_c[i]);
            check_eq($sformatf("%s.cmem%0d", name, i), c_mem[i], exp_c[i]);
        end
        check_eq({name, ".first_wr"}, first_wr, 10);
        check_eq({name, ".done_cyc"}, done_cyc, 14);
        check_eq({name, ".ndone"}, ndone, 1);
        check_eq({name, ".busy_cycles"}, nbusy, 14);
        check_eq({name, ".ovf"}, int'(bus.ovf), int'(exp_ovf));
        $display("%s: run exp=%0d/%0d/%0d/%0d ovf=%0d", name, exp_c[0], exp_c[1], exp_c[2], exp_c[3], exp_ovf);
    endtask

    // Abort a run with reset during the write phase, then run cleanly
    task automatic reset_abort();
        int nwr = 0;
        load_default();
        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        check_eq("rst_abort.wr_en", int'(bus.wr_en), 0);
        check_eq("rst_abort.busy", int'(bus.busy), 0);
        check_eq("rst_abort.done", int'(bus.done), 0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (bus.wr_en) nwr++;
        end
        check_eq("rst_abort.writes_in_reset", nwr, 0);
        rst = 1'b1;
        $display("rst_abort: reset released");
        for (int i = 0; i < 4; i++) c_mem[i] = -1;
        run_conv("after_rst", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 25; i++) img[i] = 0;
        load_default();
        repeat (3) @(negedge clk);
        check_eq("reset.wr_en", int'(bus.wr_en), 0);
        check_eq("reset.wr_addr", int'(bus.wr_addr), 0);
        check_eq("reset.wr_data", int'(bus.wr_data), 0);
        check_eq("reset.busy", int'(bus.busy), 0);
        check_eq("reset.done", int'(bus.done), 0);
        check_eq("reset.ovf", int'(bus.ovf), 0);
        rst = 1'b1;
        @(negedge clk);

        // Reference data, timing
        run_conv("default", 1'b1, 1'b0, 1'b0);

        // Saturation: A all 255, B all 1
        for (int i = 0; i < 16; i++) img[i] = 255;
        for (int i = 16; i < 25; i++) img[i] = 1;
        run_conv("sat", 1'b0, 1'b0, 1'b0);
        check_eq("sat.c00", exp_c[0] == 255 ? int'(bus.ovf) : 0, 1);

        // Default data again clears ovf
        load_default();
        run_conv("ovf_clear", 1'b1, 1'b0, 1'b0);

        // Starts while busy are ignored
        run_conv("busy_start", 1'b1, 1'b1, 1'b0);

        // Operand snapshot: a00 overwritten during MAC
        run_conv("snapshot", 1'b1, 1'b0, 1'b1);

        // Reset mid-write, then a clean run
        reset_abort();

        // Randomized operands; odd runs biased high to provoke saturation
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 25; i++)
                img[i] = (r % 2 == 1) ? int'($urandom_range(255, 120)) : int'($urandom_range(255, 0));
            if (r % 4 == 0)
                for (int i = 16; i < 25; i++) img[i] = int'($urandom_range(3, 0));
            run_conv($sformatf("rand%0d", r), 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_engine.md
Name: conv_engine

Overview:
- Downstream consumer of the 29-byte operand/result RAM.
- Reads the 4x4 input matrix A (a00..a33) and the 3x3 kernel B (b00..b22) from the RAM's parallel outputs.
- Computes the 2x2 valid convolution C[i][j] = sum over k,l of A[i+k][j+l]*B[k][l] on a 2x2 array of MAC processing elements.
- Writes the four results back through the RAM write port (in/addr/en) at addresses 25..28.

Parameters:
- DW, 8: operand and result data width.
- AW, 5: RAM address width.
- ACCW, 20: accumulator width; holds 9*255*255 without overflow.
- C_BASE, 25: RAM address of C00. C01, C10 and C11 follow at +1, +2, +3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle request to run a convolution; sampled only in IDLE.
- a00..a33  input  8 each  matrix A from RAM, row-major (16 ports).
- b00..b22  input  8 each  kernel B from RAM, row-major (9 ports).
- wr_en  output  1  RAM write enable; drives RAM en.
- wr_addr  output  5  RAM write address; drives RAM addr.
- wr_data  output  8  RAM write data; drives RAM in.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when all four results have been written.
- ovf  output  1  sticky: set if any result saturated in the current run; cleared by an accepted start.

Behaviour:
- Reset: rst low asynchronously forces:
  - state=IDLE;
  - wr_en, wr_addr, wr_data, busy, done, ovf all 0;
  - accumulators, tap counter, write index and operand snapshot cleared.
- Reset asserted mid-run aborts the run; no further writes are issued.
- All outputs are registered, or decoded purely from state registers.
- IDLE: on the edge where start=1:
  - snapshot all 25 operands into internal registers;
  - clear the 4 accumulators and ovf;
  - set tap k=0 and go to MAC.
- RAM changes after this edge do not affect the run.
- MAC (9 cycles, k=0..8, with kr=k/3 and kc=k%3): each edge, PE(i,j) does acc += A[i+kr][j+kc]*B[kr][kc].
  - Products are 16-bit unsigned; the accumulator is ACCW-bit unsigned.
  - The edge with k=8 moves to WRITE with idx=0.
- WRITE (4 cycles, idx=0..3 in order C00, C01, C10, C11):
  - wr_en=1, wr_addr=C_BASE+idx;
  - wr_data = acc[idx] if acc[idx] <= 255, else 255 with ovf set.
  - After idx=3 go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge E0. Writes are visible in the cycles after E9..E12; done is high in the cycle after E13; busy returns low after E14.
- start while busy is ignored; there is no queuing.
- start held high continuously re-launches on the first IDLE cycle after DONE.
- wr_addr and wr_data hold their last values when wr_en=0.
- Writes target only addresses 25..28; A and B storage is never written.

Decomposition:
- Shared include conv_defs.vh:
  - DW, AW, ACCW;
  - RAM address constants (A base 0, B base 16, C base 25);
  - state encodings IDLE/MAC/WRITE/DONE.
- One sub-module, conv_pe: a single MAC cell.
  - Ports: clk, rst, clr, en, a[7:0], b[7:0], acc[ACCW-1:0].
  - Instantiated 2x2.
- Top level holds the FSM, tap counter, operand mux and write sequencer.

Test Plan:
- RAM reset contents:
  - A rows: 4 6 5 1 / 1 2 3 4 / 7 8 9 3 / 5 7 2 7.
  - B rows: 2 3 2 / 4 6 5 / 1 7 1.
  - Stimulus: pulse start.
  - Expected: writes addr25=139, addr26=149, addr27=191, addr28=150 on consecutive cycles; done one cycle later; ovf=0.
- Timing check, same run: first wr_en exactly 10 cycles after the start edge; busy high for 14 cycles.
- A all 255, B all 1: all four writes are 255 and ovf=1. A following run with the default data clears ovf to 0.
- start pulsed at cycles 3 and 12 of a run: ignored; exactly 4 writes and 1 done.
- Operand snapshot: overwrite a00 to 0 via an external RAM write during MAC. C00 is still 139.
- rst driven low during the WRITE phase: wr_en, busy and done drop to 0 immediately with no clock edge needed. After release and a new start, a full correct run of 139/149/191/150 completes.
